// File: rtl/ctrl_unit_pkg.sv
// Shared definitions for the instruction control unit.
//   - opcode constants and opcode classification helper
//   - FSM state encoding
//   - instruction field offsets and the fixed ALU code used by CMP
package ctrl_unit_pkg;

  // Opcodes 0..7 drive the ALU directly with alu_ctrl = opcode[2:0].
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_2   = 4'h2;
  localparam logic [3:0] OP_3   = 4'h3;
  localparam logic [3:0] OP_4   = 4'h4;
  localparam logic [3:0] OP_5   = 4'h5;
  localparam logic [3:0] OP_6   = 4'h6;
  localparam logic [3:0] OP_7   = 4'h7;
  localparam logic [3:0] OP_CMP = 4'h8;

  // Each register field occupies a 4-bit slot; only the low REG_ADDR_W bits are used.
  localparam int unsigned SRC2_LSB = 0;
  localparam int unsigned SRC1_LSB = 4;
  localparam int unsigned DST_LSB  = 8;

  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_CMP,
    CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    if (!op[3]) begin
      return CLS_ALU;
    end else if (op == OP_CMP) begin
      return CLS_CMP;
    end
    return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/ctrl_unit_fsm_if.sv
// Instruction / register-file / ALU signal bundle for ctrl_unit_fsm.
//   master: instruction source + ALU flags in, control outputs observed
//   slave : the control unit itself
// Signals: ir_data, ir_valid, ir_ready, cy, zero, addr1, addr2, wr_addr,
//          rd, wr, alu_ctrl, cy_q, zero_q, illegal, busy
interface ctrl_unit_fsm_if #(
  parameter int unsigned IR_W       = 16,
  parameter int unsigned REG_ADDR_W = 3
);

  logic [IR_W-1:0]       ir_data;
  logic                  ir_valid;
  logic                  ir_ready;
  logic                  cy;
  logic                  zero;
  logic [REG_ADDR_W-1:0] addr1;
  logic [REG_ADDR_W-1:0] addr2;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic                  rd;
  logic                  wr;
  logic [2:0]            alu_ctrl;
  logic                  cy_q;
  logic                  zero_q;
  logic                  illegal;
  logic                  busy;

  modport master (
    output ir_data, ir_valid, cy, zero,
    input  ir_ready, addr1, addr2, wr_addr, rd, wr, alu_ctrl, cy_q, zero_q, illegal, busy
  );

  modport slave (
    input  ir_data, ir_valid, cy, zero,
    output ir_ready, addr1, addr2, wr_addr, rd, wr, alu_ctrl, cy_q, zero_q, illegal, busy
  );

endinterface

// File: rtl/ctrl_ir_decode.sv
// Combinational instruction decoder.
//   i_ir       : instruction word being latched
//   o_class    : ALU op, CMP or illegal
//   o_alu_ctrl : ALU operation select (SUB for CMP)
//   o_addr1/2  : register-file read addresses
//   o_wr_addr  : write-back address
module ctrl_ir_decode
  import ctrl_unit_pkg::*;
#(
  parameter int unsigned IR_W       = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic [IR_W-1:0]       i_ir,
  output op_class_e             o_class,
  output logic [2:0]            o_alu_ctrl,
  output logic [REG_ADDR_W-1:0] o_addr1,
  output logic [REG_ADDR_W-1:0] o_addr2,
  output logic [REG_ADDR_W-1:0] o_wr_addr
);

  logic [3:0] w_opcode;
  logic       w_unused_ir;

  assign w_opcode   = i_ir[IR_W-1 -: 4];
  assign o_class    = op_class(w_opcode);
  assign o_alu_ctrl = (o_class == CLS_CMP) ? ALU_SUB : w_opcode[2:0];

  // Slot bits above REG_ADDR_W are dropped by the part-select width.
  assign o_addr1    = i_ir[SRC1_LSB +: REG_ADDR_W];
  assign o_addr2    = i_ir[SRC2_LSB +: REG_ADDR_W];
  assign o_wr_addr  = i_ir[DST_LSB +: REG_ADDR_W];

  // Padding and spare field bits carry no meaning.
  assign w_unused_ir = ^i_ir;

endmodule

// File: rtl/ctrl_unit_fsm.sv
// Multi-cycle instruction control unit.
// Accepts one instruction per ir_valid/ir_ready handshake, then sequences
// READ -> EXEC (EXEC_CYCLES) -> WB for ALU ops, or READ -> EXEC for CMP.
// ALU flags are captured on the last EXEC cycle; illegal opcodes raise a
// one-cycle pulse and leave the unit idle.
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : ctrl_unit_fsm_if slave modport (handshake, flags, register-file/ALU controls)
// Every output is a flop; nothing on the bus input side reaches an output combinationally.
module ctrl_unit_fsm
  import ctrl_unit_pkg::*;
#(
  parameter int unsigned IR_W        = 16,
  parameter int unsigned REG_ADDR_W  = 3,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  ctrl_unit_fsm_if.slave bus
);

  localparam logic [2:0] EXEC_LAST = 3'(EXEC_CYCLES - 1);

  // Decoder outputs for the incoming word.
  op_class_e             w_class;
  logic [2:0]            w_dec_alu;
  logic [REG_ADDR_W-1:0] w_dec_addr1;
  logic [REG_ADDR_W-1:0] w_dec_addr2;
  logic [REG_ADDR_W-1:0] w_dec_wr_addr;

  state_e                r_state,    w_state_d;
  logic [2:0]            r_exec_cnt, w_exec_cnt_d;
  logic                  r_is_cmp,   w_is_cmp_d;
  logic                  r_ir_ready, w_ir_ready_d;
  logic                  r_rd,       w_rd_d;
  logic                  r_wr,       w_wr_d;
  logic                  r_illegal,  w_illegal_d;
  logic                  r_busy,     w_busy_d;
  logic                  r_cy_q,     w_cy_d;
  logic                  r_zero_q,   w_zero_d;
  logic [2:0]            r_alu_ctrl, w_alu_ctrl_d;
  logic [REG_ADDR_W-1:0] r_addr1,    w_addr1_d;
  logic [REG_ADDR_W-1:0] r_addr2,    w_addr2_d;
  logic [REG_ADDR_W-1:0] r_wr_addr,  w_wr_addr_d;

  logic                  w_accept;
  logic                  w_exec_last;

  ctrl_ir_decode #(
    .IR_W       (IR_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_decode (
    .i_ir       (bus.ir_data),
    .o_class    (w_class),
    .o_alu_ctrl (w_dec_alu),
    .o_addr1    (w_dec_addr1),
    .o_addr2    (w_dec_addr2),
    .o_wr_addr  (w_dec_wr_addr)
  );

  // r_ir_ready is only set in IDLE, so it doubles as the "can accept" qualifier.
  assign w_accept    = r_ir_ready & bus.ir_valid;
  assign w_exec_last = (r_exec_cnt == EXEC_LAST);

  // Output flops hold the values for the state being entered, so each
  // output is valid for exactly the cycle its state occupies.
  always_comb begin
    w_state_d    = r_state;
    w_exec_cnt_d = r_exec_cnt;
    w_is_cmp_d   = r_is_cmp;
    w_ir_ready_d = 1'b0;
    w_rd_d       = 1'b0;
    w_wr_d       = 1'b0;
    w_illegal_d  = 1'b0;
    w_cy_d       = r_cy_q;
    w_zero_d     = r_zero_q;
    w_alu_ctrl_d = r_alu_ctrl;
    w_addr1_d    = r_addr1;
    w_addr2_d    = r_addr2;
    w_wr_addr_d  = r_wr_addr;

    unique case (r_state)
      IDLE: begin
        w_ir_ready_d = 1'b1;
        if (w_accept) begin
          if (w_class == CLS_ILLEGAL) begin
            // Unit stays idle and ready; fields and flags are left untouched.
            w_illegal_d = 1'b1;
          end else begin
            w_state_d    = READ;
            w_ir_ready_d = 1'b0;
            w_rd_d       = 1'b1;
            w_is_cmp_d   = (w_class == CLS_CMP);
            w_alu_ctrl_d = w_dec_alu;
            w_addr1_d    = w_dec_addr1;
            w_addr2_d    = w_dec_addr2;
            w_wr_addr_d  = w_dec_wr_addr;
          end
        end
      end
      READ: begin
        w_state_d    = EXEC;
        w_exec_cnt_d = '0;
        w_rd_d       = 1'b1;
      end
      EXEC: begin
        if (w_exec_last) begin
          w_cy_d       = bus.cy;
          w_zero_d     = bus.zero;
          w_exec_cnt_d = '0;
          if (r_is_cmp) begin
            w_state_d    = IDLE;
            w_ir_ready_d = 1'b1;
          end else begin
            w_state_d = WB;
            w_wr_d    = 1'b1;
          end
        end else begin
          w_exec_cnt_d = r_exec_cnt + 3'd1;
          w_rd_d       = 1'b1;
        end
      end
      WB: begin
        w_state_d    = IDLE;
        w_ir_ready_d = 1'b1;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase

    w_busy_d = (w_state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_exec_cnt <= '0;
      r_is_cmp   <= 1'b0;
      r_ir_ready <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_illegal  <= 1'b0;
      r_busy     <= 1'b0;
      r_cy_q     <= 1'b0;
      r_zero_q   <= 1'b0;
      r_alu_ctrl <= '0;
      r_addr1    <= '0;
      r_addr2    <= '0;
      r_wr_addr  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_exec_cnt <= w_exec_cnt_d;
      r_is_cmp   <= w_is_cmp_d;
      r_ir_ready <= w_ir_ready_d;
      r_rd       <= w_rd_d;
      r_wr       <= w_wr_d;
      r_illegal  <= w_illegal_d;
      r_busy     <= w_busy_d;
      r_cy_q     <= w_cy_d;
      r_zero_q   <= w_zero_d;
      r_alu_ctrl <= w_alu_ctrl_d;
      r_addr1    <= w_addr1_d;
      r_addr2    <= w_addr2_d;
      r_wr_addr  <= w_wr_addr_d;
    end
  end

  assign bus.ir_ready = r_ir_ready;
  assign bus.rd       = r_rd;
  assign bus.wr       = r_wr;
  assign bus.illegal  = r_illegal;
  assign bus.busy     = r_busy;
  assign bus.cy_q     = r_cy_q;
  assign bus.zero_q   = r_zero_q;
  assign bus.alu_ctrl = r_alu_ctrl;
  assign bus.addr1    = r_addr1;
  assign bus.addr2    = r_addr2;
  assign bus.wr_addr  = r_wr_addr;

endmodule

// File: tb/tb_ctrl_unit_fsm.sv
// Directed bench for ctrl_unit_fsm: one instance with EXEC_CYCLES=1, one with 4.
module tb_ctrl_unit_fsm;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  ctrl_unit_fsm_if #(.IR_W(16), .REG_ADDR_W(3)) bus1 ();
  ctrl_unit_fsm_if #(.IR_W(16), .REG_ADDR_W(3)) bus4 ();

  ctrl_unit_fsm #(
    .IR_W        (16),
    .REG_ADDR_W  (3),
    .EXEC_CYCLES (1)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  ctrl_unit_fsm #(
    .IR_W        (16),
    .REG_ADDR_W  (3),
    .EXEC_CYCLES (4)
  ) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack1();
    return {13'd0, bus1.ir_ready, bus1.rd, bus1.wr, bus1.illegal, bus1.busy, bus1.cy_q,
            bus1.zero_q, bus1.alu_ctrl, bus1.addr1, bus1.addr2, bus1.wr_addr};
  endfunction

  function automatic logic [31:0] pack4();
    return {13'd0, bus4.ir_ready, bus4.rd, bus4.wr, bus4.illegal, bus4.busy, bus4.cy_q,
            bus4.zero_q, bus4.alu_ctrl, bus4.addr1, bus4.addr2, bus4.wr_addr};
  endfunction

  initial begin
    rst           = 1'b1;
    bus1.ir_valid = 1'b0;
    bus1.ir_data  = '0;
    bus1.cy       = 1'b0;
    bus1.zero     = 1'b0;
    bus4.ir_valid = 1'b0;
    bus4.ir_data  = '0;
    bus4.cy       = 1'b0;
    bus4.zero     = 1'b0;

    // Reset: all outputs 0 while held, ready one edge after release.
    #1;
    check("rst_outs1", pack1(), 32'd0);
    check("rst_outs4", pack4(), 32'd0);
    repeat (3) begin
      step();
      check("rst_hold", pack1(), 32'd0);
    end
    rst = 1'b0;
    check("ready_pre_edge", bus1.ir_ready, 1'b0);
    step();
    check("ready_post_rel", bus1.ir_ready, 1'b1);
    check("busy_idle", bus1.busy, 1'b0);

    // ADD 0312, EXEC_CYCLES=1.
    bus1.ir_data  = 16'h0312;
    bus1.ir_valid = 1'b1;
    step();                                       // T+1 READ
    bus1.ir_valid = 1'b0;
    check("add_read_rd", bus1.rd, 1'b1);
    check("add_read_wr", bus1.wr, 1'b0);
    check("add_addr1", bus1.addr1, 3'd1);
    check("add_addr2", bus1.addr2, 3'd2);
    check("add_alu", bus1.alu_ctrl, 3'd0);
    check("add_ready_lo", bus1.ir_ready, 1'b0);
    check("add_busy", bus1.busy, 1'b1);
    step();                                       // T+2 EXEC
    check("add_exec_rd", bus1.rd, 1'b1);
    check("add_exec_wr", bus1.wr, 1'b0);
    step();                                       // T+3 WB
    check("add_wb_wr", bus1.wr, 1'b1);
    check("add_wb_rd", bus1.rd, 1'b0);
    check("add_wb_addr", bus1.wr_addr, 3'd3);
    check("add_wb_ready", bus1.ir_ready, 1'b0);
    step();                                       // T+4 IDLE
    check("add_done_wr", bus1.wr, 1'b0);
    check("add_done_ready", bus1.ir_ready, 1'b1);
    check("add_done_busy", bus1.busy, 1'b0);
    check("add_flags", {bus1.cy_q, bus1.zero_q}, 2'b00);

    // CMP 8045 with flags high on the last EXEC cycle only.
    bus1.ir_data  = 16'h8045;
    bus1.ir_valid = 1'b1;
    step();                                       // T+1 READ
    bus1.ir_valid = 1'b0;
    check("cmp_alu", bus1.alu_ctrl, 3'b001);
    check("cmp_addr1", bus1.addr1, 3'd4);
    check("cmp_addr2", bus1.addr2, 3'd5);
    check("cmp_rd", bus1.rd, 1'b1);
    step();                                       // T+2 last EXEC
    bus1.cy   = 1'b1;
    bus1.zero = 1'b1;
    check("cmp_flags_pre", {bus1.cy_q, bus1.zero_q}, 2'b00);
    check("cmp_exec_wr", bus1.wr, 1'b0);
    step();                                       // T+3 IDLE
    bus1.cy   = 1'b0;
    bus1.zero = 1'b0;
    check("cmp_flags", {bus1.cy_q, bus1.zero_q}, 2'b11);
    check("cmp_no_wr", bus1.wr, 1'b0);
    check("cmp_ready", bus1.ir_ready, 1'b1);
    check("cmp_busy", bus1.busy, 1'b0);

    // Illegal F000.
    bus1.ir_data  = 16'hF000;
    bus1.ir_valid = 1'b1;
    step();
    bus1.ir_valid = 1'b0;
    check("ill_pulse", bus1.illegal, 1'b1);
    check("ill_rdwr", {bus1.rd, bus1.wr}, 2'b00);
    check("ill_busy", bus1.busy, 1'b0);
    check("ill_ready", bus1.ir_ready, 1'b1);
    check("ill_flags", {bus1.cy_q, bus1.zero_q}, 2'b11);
    check("ill_addr_hold", bus1.addr1, 3'd4);
    step();
    check("ill_pulse_end", bus1.illegal, 1'b0);
    check("ill_flags_after", {bus1.cy_q, bus1.zero_q}, 2'b11);

    // EXEC_CYCLES=4: ADD 0512, second request held off while busy.
    bus4.ir_data  = 16'h0512;
    bus4.ir_valid = 1'b1;
    step();                                       // T+1
    bus4.ir_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin             // T+1..T+5
      check("e4_rd", bus4.rd, 1'b1);
      check("e4_wr_lo", bus4.wr, 1'b0);
      check("e4_ready_lo", bus4.ir_ready, 1'b0);
      if (i == 1) begin
        bus4.ir_data  = 16'h0634;
        bus4.ir_valid = 1'b1;
      end
      step();
    end
    check("e4_wb_wr", bus4.wr, 1'b1);             // T+6
    check("e4_wb_rd", bus4.rd, 1'b0);
    check("e4_wb_addr", bus4.wr_addr, 3'd5);
    step();                                       // T+7
    check("e4_ready", bus4.ir_ready, 1'b1);
    step();                                       // T+8 second op READ
    bus4.ir_valid = 1'b0;
    check("e4_2nd_rd", bus4.rd, 1'b1);
    check("e4_2nd_fields", {bus4.wr_addr, bus4.addr1, bus4.addr2}, {3'd6, 3'd3, 3'd4});
    repeat (6) step();                            // T+14
    check("e4_2nd_done", bus4.ir_ready, 1'b1);

    // Mid-operation reset during EXEC.
    bus1.ir_data  = 16'h0312;
    bus1.ir_valid = 1'b1;
    step();                                       // READ
    bus1.ir_valid = 1'b0;
    step();                                       // EXEC
    rst = 1'b1;
    #2;
    check("mid_rst_outs", pack1(), 32'd0);
    #2;
    rst = 1'b0;
    step();
    check("post_rst_wr", bus1.wr, 1'b0);
    check("post_rst_ready", bus1.ir_ready, 1'b1);
    step();
    check("post_rst_wr2", bus1.wr, 1'b0);
    check("post_rst_flags", {bus1.cy_q, bus1.zero_q}, 2'b00);

    // Next instruction: opcode 7, spare slot bits set.
    bus1.ir_data  = 16'h7EBC;
    bus1.ir_valid = 1'b1;
    step();
    bus1.ir_valid = 1'b0;
    check("op7_alu", bus1.alu_ctrl, 3'd7);
    check("op7_addr1", bus1.addr1, 3'd3);
    check("op7_addr2", bus1.addr2, 3'd4);
    check("op7_rd", bus1.rd, 1'b1);
    step();
    step();
    check("op7_wr", bus1.wr, 1'b1);
    check("op7_wr_addr", bus1.wr_addr, 3'd6);
    step();
    check("op7_ready", bus1.ir_ready, 1'b1);
    check("op7_wr_end", bus1.wr, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctrl_unit_fsm.md
Name: ctrl_unit_fsm

Overview:
Parametrised, clocked successor of the processor's instruction control unit. It accepts one instruction word per valid/ready handshake and decodes opcode and register fields. It then sequences register-file read, ALU execute and register write-back as an explicit multi-cycle FSM. It also latches ALU flags and flags illegal opcodes. It sits between the instruction register and the register file / ALU pair.

Parameters:
IR_W, 16, instruction width; opcode is ir_data[IR_W-1 -: 4]; must be >= 16.
REG_ADDR_W, 3, register address width; legal range 1..4.
EXEC_CYCLES, 1, cycles the ALU is held before write-back/flag capture; legal range 1..8.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
ir_data  in  IR_W  instruction word
ir_valid  in  1  instruction word present
ir_ready  out  1  unit can accept an instruction (IDLE state only)
cy  in  1  ALU carry, sampled on the last EXEC cycle
zero  in  1  ALU zero, sampled on the last EXEC cycle
addr1  out  REG_ADDR_W  register-file read port 1 address = ir_data[4 +: REG_ADDR_W]
addr2  out  REG_ADDR_W  register-file read port 2 address = ir_data[0 +: REG_ADDR_W]
wr_addr  out  REG_ADDR_W  write-back address = ir_data[8 +: REG_ADDR_W]
rd  out  1  register-file read enable
wr  out  1  register-file write enable, single-cycle pulse
alu_ctrl  out  3  ALU operation select
cy_q  out  1  latched carry flag
zero_q  out  1  latched zero flag
illegal  out  1  one-cycle pulse on an illegal opcode
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: clk and reset are fixed as one clock; reset is asynchronous and active-high. While rst is high, every output is 0, state is IDLE, and the exec counter is 0. ir_ready rises on the first clock edge after rst is released.
- All outputs are registered. No combinational path exists from any input to any output.
- Opcode map:
  - 0000-0111: ALU ops; alu_ctrl = opcode[2:0]; write-back is performed.
  - 1000: CMP; alu_ctrl = 3'b001 (sub); flags are updated; no write-back.
  - 1001-1111: illegal.
- States: IDLE, READ, EXEC, WB.
- IDLE: ir_ready=1, rd=0, wr=0.
  - On ir_valid && ir_ready at edge T, the instruction is latched internally.
  - For an illegal opcode: illegal=1 during cycle T+1, state stays IDLE, and ir_ready stays 1.
  - For a legal opcode: go to READ; ir_ready=0.
- READ (one cycle, T+1): addr1/addr2/wr_addr are driven from the latched word; rd=1; alu_ctrl is set. Go to EXEC.
- EXEC (EXEC_CYCLES cycles): rd=1; addresses and alu_ctrl are held.
  - On the last EXEC cycle edge, cy_q<=cy and zero_q<=zero.
  - Next state is WB for ALU ops, and IDLE for CMP.
- WB (one cycle): wr=1, rd=0, wr_addr held. Next state is IDLE.
- Latency:
  - ALU op: accept at T, wr high in cycle T+2+EXEC_CYCLES, ready again at T+3+EXEC_CYCLES.
  - CMP: ready again at T+2+EXEC_CYCLES.
- Flags persist between instructions. Illegal opcodes never modify the flags.
- addr1/addr2/wr_addr/alu_ctrl hold their last values in IDLE. rd and wr are 0 in IDLE.
- ir_data and ir_valid are ignored while busy. ir_valid has no effect in reset.
- Reset asserted mid-instruction: FSM aborts immediately to IDLE. No wr pulse is emitted and flags clear to 0.
- Field bits above REG_ADDR_W inside each 4-bit slot are ignored.
- wr and rd are never high in the same cycle.

Decomposition:
- ctrl_unit_pkg holds:
  - opcode constants (OP_ADD..OP_7, OP_CMP);
  - state enum (IDLE, READ, EXEC, WB);
  - field offsets (SRC2_LSB=0, SRC1_LSB=4, DST_LSB=8);
  - ALU_SUB=3'b001.
- One sub-module, ctrl_ir_decode, is natural. It is combinational and maps the latched IR to opcode class (alu, cmp, illegal), alu_ctrl and the three addresses.
- The FSM and exec counter stay in ctrl_unit_fsm.

Test Plan:
- Reset and handshake: rst high 3 cycles then low → all outputs 0 during reset, ir_ready=1 one edge after release.
- ADD: ir_data=16'h0312 (defaults), EXEC_CYCLES=1 → READ cycle with addr1=1, addr2=2, rd=1, alu_ctrl=0; wr=1 with wr_addr=3 exactly at T+3; ir_ready back at T+4.
- CMP: ir_data=16'h8045 with cy=1, zero=1 on the last EXEC cycle → cy_q=1, zero_q=1; wr never asserted; ready at T+3.
- Illegal: ir_data=16'hF000 → illegal=1 for one cycle; no rd/wr; flags unchanged; busy stays 0.
- EXEC_CYCLES=4 build: ADD 16'h0512 → rd high for 5 cycles, wr at T+6; a second ir_valid during busy is not accepted until IDLE.
- Mid-operation reset: assert rst during EXEC → outputs 0 asynchronously; no wr pulse after release; next instruction executes normally.
